// File: rtl/timing_phase_generator.sv
// Machine-cycle phase sequencer: ten one-hot phase strobes, each PHASE_DIV clocks long,
// started by a level run or a single-shot step, with a registered completion counter.
module timing_phase_generator #(
    parameter int PHASE_DIV = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    output logic [10:1]      tn,
    output logic             t_romn,
    output logic             busy,
    output logic             cycle_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic             fsm_state
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam logic [7:0] SUB_LAST   = 8'(PHASE_DIV - 1);
    localparam logic [3:0] PHASE_LAST = 4'd10;

    state_e     state;
    state_e     state_nx;
    logic [3:0] phase;
    logic [3:0] phase_nx;
    logic [7:0] sub;
    logic [7:0] sub_nx;

    logic [10:1] tn_nx;
    logic        t_romn_nx;
    logic        busy_nx;
    logic        done_nx;

    // Outputs are registered from the next-state values, so they line up with
    // the state they describe and never see run/step combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= 4'd0;
            sub         <= 8'd0;
            tn          <= '0;
            t_romn      <= 1'b1;
            busy        <= 1'b0;
            cycle_done  <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            sub         <= sub_nx;
            tn          <= tn_nx;
            t_romn      <= t_romn_nx;
            busy        <= busy_nx;
            cycle_done  <= done_nx;
            if (cycle_done) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        sub_nx   = sub;
        case (state)
            IDLE: begin
                if (run || step) begin
                    state_nx = ACTIVE;
                    phase_nx = 4'd1;
                    sub_nx   = 8'd0;
                end
            end
            ACTIVE: begin
                if (sub == SUB_LAST) begin
                    sub_nx = 8'd0;
                    if (phase == PHASE_LAST) begin
                        // Only run can chain cycles; step is never looked at here.
                        if (run) begin
                            phase_nx = 4'd1;
                        end else begin
                            state_nx = IDLE;
                            phase_nx = 4'd0;
                        end
                    end else begin
                        phase_nx = phase + 4'd1;
                    end
                end else begin
                    sub_nx = sub + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                phase_nx = 4'd0;
                sub_nx   = 8'd0;
            end
        endcase
    end

    always_comb begin
        tn_nx = '0;
        for (int i = 1; i <= 10; i++) begin
            tn_nx[i] = (state_nx == ACTIVE) && (phase_nx == 4'(i));
        end
        busy_nx   = (state_nx == ACTIVE);
        t_romn_nx = ~tn_nx[1];
        done_nx   = busy_nx && (phase_nx == PHASE_LAST) && (sub_nx == SUB_LAST);
    end

    assign fsm_state = (state == ACTIVE);

endmodule

// File: tb/tb_timing_phase_generator.sv
// Bench for timing_phase_generator: two instances (divide-by-4 / 16-bit count and
// divide-by-1 / 4-bit count), expected per-clock output words held in queues.
module tb_timing_phase_generator;

    localparam int W = 30;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic        run_a = 1'b0;
    logic        step_a = 1'b0;
    logic [10:1] tn_a;
    logic        t_romn_a, busy_a, cycle_done_a, fsm_state_a;
    logic [15:0] cycle_count_a;

    logic        reset_b = 1'b1;
    logic        run_b = 1'b0;
    logic        step_b = 1'b0;
    logic [10:1] tn_b;
    logic        t_romn_b, busy_b, cycle_done_b, fsm_state_b;
    logic [3:0]  cycle_count_b;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];

    int n_vec  = 0;
    int n_miss = 0;

    timing_phase_generator #(.PHASE_DIV(4), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset_a), .run(run_a), .step(step_a),
        .tn(tn_a), .t_romn(t_romn_a), .busy(busy_a), .cycle_done(cycle_done_a),
        .cycle_count(cycle_count_a), .fsm_state(fsm_state_a)
    );

    timing_phase_generator #(.PHASE_DIV(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset_b), .run(run_b), .step(step_b),
        .tn(tn_b), .t_romn(t_romn_b), .busy(busy_b), .cycle_done(cycle_done_b),
        .cycle_count(cycle_count_b), .fsm_state(fsm_state_b)
    );

    always #5 clk = ~clk;

    // Word layout: {count[15:0], tn[10:1], t_romn, busy, cycle_done, fsm_state}.
    function automatic logic [W-1:0] exp_word(input int p, input bit done, input int cnt);
        logic [9:0] t;
        logic       act;
        t   = '0;
        act = (p != 0);
        if (act) t[p-1] = 1'b1;
        return {16'(cnt), t, ~t[0], act, done, act};
    endfunction

    task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic push_cycle(input bit to_b, input int div, input int cnt, input int nclk);
        int k;
        k = 0;
        for (int p = 1; p <= 10; p++) begin
            for (int s = 0; s < div; s++) begin
                if (k < nclk) begin
                    if (to_b) exp_b.push_back(exp_word(p, (p == 10) && (s == div - 1), cnt));
                    else      exp_a.push_back(exp_word(p, (p == 10) && (s == div - 1), cnt));
                end
                k++;
            end
        end
    endtask

    task automatic push_idle(input bit to_b, input int cnt, input int n);
        for (int i = 0; i < n; i++) begin
            if (to_b) exp_b.push_back(exp_word(0, 1'b0, cnt));
            else      exp_a.push_back(exp_word(0, 1'b0, cnt));
        end
    endtask

    task automatic tick();
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            check_vec("dut_a", {cycle_count_a, tn_a, t_romn_a, busy_a, cycle_done_a, fsm_state_a}, e);
        end
        if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            check_vec("dut_b", {12'd0, cycle_count_b, tn_b, t_romn_b, busy_b, cycle_done_b, fsm_state_b}, e);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_a.size() > 0 || exp_b.size() > 0) && guard < 1000) begin
            tick();
            guard++;
        end
        if (guard >= 1000) begin
            n_miss++;
            $display("FAIL drain_timeout: %0d/%0d words left, required 0", exp_a.size(), exp_b.size());
        end
    endtask

    initial begin
        int i;

        // Reset then idle for five clocks.
        push_idle(0, 0, 6);
        tick();
        reset_a = 1'b0;
        drain();

        // Single step cycle.
        push_cycle(0, 4, 0, 40);
        push_idle(0, 1, 2);
        step_a = 1'b1;
        tick();
        step_a = 1'b0;
        drain();

        // Step pulses during tn[3] and in the last clk of tn[10] are ignored.
        push_cycle(0, 4, 1, 40);
        push_idle(0, 2, 2);
        step_a = 1'b1;
        tick();
        for (int k = 1; k <= 41; k++) begin
            step_a = (k == 10 || k == 40);
            tick();
        end
        step_a = 1'b0;
        drain();

        // Run back-to-back, dropped during tn[4] of the 4th cycle.
        for (int c = 0; c < 4; c++) push_cycle(0, 4, 2 + c, 40);
        push_idle(0, 6, 2);
        i = 0;
        while (exp_a.size() > 0 && i < 400) begin
            run_a = (i < 134);
            tick();
            i++;
        end
        run_a = 1'b0;
        drain();

        // Reset during tn[5], with run asserted in the same clk.
        push_cycle(0, 4, 6, 18);
        push_idle(0, 0, 3);
        step_a = 1'b1;
        tick();
        step_a = 1'b0;
        for (int k = 1; k <= 17; k++) tick();
        reset_a = 1'b1;
        run_a   = 1'b1;
        tick();
        reset_a = 1'b0;
        run_a   = 1'b0;
        drain();

        // Divide-by-1, 4-bit counter, run and step together: 17 chained cycles.
        push_idle(1, 0, 1);
        tick();
        reset_b = 1'b0;
        for (int c = 0; c < 17; c++) push_cycle(1, 1, c & 15, 10);
        push_idle(1, 1, 2);
        i = 0;
        while (exp_b.size() > 0 && i < 400) begin
            run_b  = (i < 165);
            step_b = (i == 0);
            tick();
            i++;
        end
        run_b  = 1'b0;
        step_b = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
